// File: rtl/uart_rx_packet_ctrl_pkg.sv
// uart_rx_packet_ctrl_pkg
//   Shared definitions for the UART receive packet controller.
//   Contents: FSM state encoding, default SYNC byte, and a clog2 helper
//   that is wide enough to size the inter-byte timeout counter.
//   Optional feature macro used by the top level: UART_RX_ERR_STATS_EN.
package uart_rx_packet_ctrl_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Ceiling log2 over a 64-bit argument; the timeout product can exceed 2^31.
  function automatic int clog2_l(input longint value);
    int     r;
    longint v;
    r = 0;
    v = value - 64'sd1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_packet_ctrl_rx_pkt_buffer.sv
// rx_pkt_buffer
//   Payload store for one packet: DEPTH x 8 register array.
//   Synchronous write, combinational read, no reset on the storage.
// Ports
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_idx   in   write index
//   wr_data  in   byte to store
//   rd_idx   in   read index
//   rd_data  out  byte at rd_idx
module rx_pkt_buffer #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl
//   Assembles bytes from the UART receiver core into packets of the form
//   SYNC, LEN, LEN payload bytes, CHK (XOR over LEN and payload), and
//   releases the payload on a valid/ready stream only after the check passes.
//   Optional macro UART_RX_ERR_STATS_EN builds the saturating drop counter;
//   without it err_cnt is tied to zero and stats_clr is ignored.
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   rx_valid/rx_err     per-byte strobes from the receiver core
//   rx_data             received byte
//   pkt_data/valid/last payload stream out, pkt_ready from the consumer
//   pkt_ok/pkt_bad      one-cycle packet verdict pulses
//   rx_overrun          one-cycle pulse when a byte arrives while draining
//   ctrl_busy           high whenever the FSM is not hunting for SYNC
//   stats_clr/err_cnt   drop counter clear and value
//
// state   | meaning
// HUNT    | waiting for SYNC_BYTE
// LEN     | expecting the length byte
// PAYLOAD | storing payload bytes, accumulating checksum
// CHK     | expecting the checksum byte
// DRAIN   | presenting the buffered payload on the output stream
module uart_rx_packet_ctrl
  import uart_rx_packet_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN       = 16,
  parameter int         CLK_RATE      = 100_000_000,
  parameter int         BAUD_RATE     = 19200,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic [7:0] rx_data,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       pkt_ok,
  output logic       pkt_bad,
  output logic       rx_overrun,
  output logic       ctrl_busy,
  input  logic       stats_clr,
  output logic [7:0] err_cnt
);

  // One character is 10 bit times; computed in 64 bits to avoid overflow.
  localparam longint TMO_L = longint'(TIMEOUT_BYTES) * 64'sd10 *
                             longint'(CLK_RATE) / longint'(BAUD_RATE);
  localparam int TW = (clog2_l(TMO_L + 64'sd1) < 1) ? 1 : clog2_l(TMO_L + 64'sd1);
  localparam logic [TW-1:0] TMO = TW'(TMO_L);
  localparam int IW = (clog2_l(longint'(MAX_LEN)) < 1) ? 1 : clog2_l(longint'(MAX_LEN));
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    len_q;
  logic [7:0]    chk_q;
  logic [IW-1:0] wr_idx_q;
  logic [IW-1:0] rd_idx_q;
  logic [7:0]    pkt_data_q;
  logic          pkt_valid_q;
  logic          pkt_last_q;
  logic          pkt_ok_q;
  logic          pkt_bad_q;
  logic          rx_overrun_q;

  logic          run_timer;
  logic          tmo_hit;
  logic          drop;
  logic          buf_wr_en;
  logic [IW-1:0] rd_addr_d;
  logic [7:0]    rd_data;

  assign run_timer = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign tmo_hit   = run_timer && (timer_q == TMO);
  // A byte error and timer expiry in the same cycle collapse into one drop.
  assign drop      = run_timer && (rx_err || tmo_hit);
  assign buf_wr_en = (state_q == PAYLOAD) && rx_valid && !drop;

  // Read address looks one ahead on a transfer so the next byte is
  // registered into pkt_data in the same cycle, giving one byte per clock.
  always_comb begin
    rd_addr_d = rd_idx_q;
    if ((state_q == DRAIN) && pkt_valid_q && pkt_ready && !pkt_last_q) begin
      rd_addr_d = rd_idx_q + IW'(1);
    end
  end

  rx_pkt_buffer #(
    .DEPTH (MAX_LEN),
    .IW    (IW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_idx  (wr_idx_q),
    .wr_data (rx_data),
    .rd_idx  (rd_addr_d),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      timer_q      <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_last_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_bad_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      pkt_ok_q     <= 1'b0;
      pkt_bad_q    <= 1'b0;
      rx_overrun_q <= 1'b0;

      if (!run_timer || rx_valid || rx_err || tmo_hit) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end

      case (state_q)
        HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q <= LEN;
          end
        end

        LEN: begin
          if (drop) begin
            pkt_bad_q <= 1'b1;
            state_q   <= HUNT;
          end else if (rx_valid) begin
            if ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B)) begin
              len_q    <= rx_data;
              chk_q    <= rx_data;
              wr_idx_q <= '0;
              state_q  <= PAYLOAD;
            end else begin
              pkt_bad_q <= 1'b1;
              state_q   <= HUNT;
            end
          end
        end

        PAYLOAD: begin
          if (drop) begin
            pkt_bad_q <= 1'b1;
            state_q   <= HUNT;
          end else if (rx_valid) begin
            chk_q    <= chk_q ^ rx_data;
            wr_idx_q <= wr_idx_q + IW'(1);
            if (8'(wr_idx_q) == (len_q - 8'd1)) begin
              state_q <= CHK;
            end
          end
        end

        CHK: begin
          if (drop) begin
            pkt_bad_q <= 1'b1;
            state_q   <= HUNT;
          end else if (rx_valid) begin
            if (rx_data == chk_q) begin
              pkt_ok_q <= 1'b1;
              rd_idx_q <= '0;
              state_q  <= DRAIN;
            end else begin
              pkt_bad_q <= 1'b1;
              state_q   <= HUNT;
            end
          end
        end

        DRAIN: begin
          if (rx_valid) begin
            rx_overrun_q <= 1'b1;
          end
          if (!pkt_valid_q) begin
            pkt_valid_q <= 1'b1;
            pkt_data_q  <= rd_data;
            pkt_last_q  <= (8'(rd_idx_q) == (len_q - 8'd1));
          end else if (pkt_ready) begin
            if (pkt_last_q) begin
              pkt_valid_q <= 1'b0;
              pkt_last_q  <= 1'b0;
              pkt_data_q  <= '0;
              state_q     <= HUNT;
            end else begin
              rd_idx_q   <= rd_addr_d;
              pkt_data_q <= rd_data;
              pkt_last_q <= (8'(rd_addr_d) == (len_q - 8'd1));
            end
          end
        end

        default: state_q <= HUNT;
      endcase
    end
  end

  assign pkt_data   = pkt_data_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_last   = pkt_last_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_bad    = pkt_bad_q;
  assign rx_overrun = rx_overrun_q;
  assign ctrl_busy  = (state_q != HUNT);

`ifdef UART_RX_ERR_STATS_EN
  logic [7:0] err_cnt_q;

  // Clear has priority over a coincident drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (stats_clr) begin
      err_cnt_q <= 8'h00;
    end else if (pkt_bad_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign err_cnt          = 8'h00;
`endif

endmodule
